alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Issue stage directly upstream of the ALU: holds the 32-entry integer register file, resolves source operands (register, immediate, or same-cycle writeback bypass) and presents them to the ALU through a one-entry valid/ready pipeline register. Writeback from the downstream stage returns through this block, and any in-flight held operand it affects is refreshed.

## Interface
- DATA_WIDTH, default `DATA_WIDTH (32): operand/register width
- OP_WIDTH, default `OP_WIDTH: ALU opcode width, passed through unchanged
- REG_ADDR_W, default 5: register index width (2**REG_ADDR_W entries)

- clk_i  in  1  single clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- In_valid_i  in  1  decoded instruction present
- In_ready_o  out  1  stage can accept this cycle
- Rs1_i  in  REG_ADDR_W  source register for A
- Rs2_i  in  REG_ADDR_W  source register for B
- Imm_i  in  DATA_WIDTH  sign-extended immediate
- UseImm_i  in  1  B = Imm_i instead of reg[Rs2_i]
- Op_i  in  OP_WIDTH  ALU opcode
- Rd_i  in  REG_ADDR_W  destination register tag
- Out_valid_o  out  1  A_o/B_o/Op_o/Rd_o valid
- Out_ready_i  in  1  ALU side consumes this cycle
- A_o, B_o  out  DATA_WIDTH  operands to ALU A_i/B_i
- Op_o  out  OP_WIDTH  opcode to ALU Op_i
- Rd_o  out  REG_ADDR_W  destination tag forwarded downstream
- Wb_en_i  in  1  writeback request
- Wb_rd_i  in  REG_ADDR_W  writeback register
- Wb_data_i  in  DATA_WIDTH  writeback value

## Operation
- Register file: 2**REG_ADDR_W x DATA_WIDTH, two combinational read ports, one write port. Register 0 reads 0 always; writes to it are dropped.
- Write: Wb_en_i && Wb_rd_i != 0 -> reg[Wb_rd_i] <= Wb_data_i at the rising edge.
- Operand resolve (combinational, at accept): A = (Wb_en_i && Wb_rd_i==Rs1_i && Rs1_i!=0) ? Wb_data_i : reg[Rs1_i]; B likewise on Rs2_i, then B = UseImm_i ? Imm_i : B.
- Issue register: one entry {A, B, Op, Rd, Rs1, Rs2, UseImm} plus valid bit; Rs1/Rs2/UseImm held internally.
- In_ready_o = !Out_valid_o || Out_ready_i (combinational; pass-through when output drains).
- Accept = In_valid_i && In_ready_o: entry loaded, Out_valid_o <= 1.
- Drain = Out_valid_o && Out_ready_i && !accept: Out_valid_o <= 0; entry content retained but don't-care.
- Held refresh: while Out_valid_o && !Out_ready_i (stalled), a Wb_en_i with Wb_rd_i != 0 matching held Rs1 replaces A_o with Wb_data_i; matching held Rs2 with held UseImm=0 replaces B_o. Both may update in one cycle.
- Accept and writeback in the same cycle: the new entry takes bypassed values; the held-refresh rule applies only to the entry not being replaced.
- No arithmetic in this block; values pass at full DATA_WIDTH without truncation or extension.

## Timing
- Reset (async assert, sync to clk_i domain on release): Out_valid_o=0, A_o=0, B_o=0, Op_o=0, Rd_o=0, all registers 0. In_ready_o=1 during and after reset.
- Reset mid-operation discards the held entry and all register contents immediately; a writeback in the reset cycle is lost.
- Latency: instruction accepted on edge N appears on A_o/B_o/Op_o/Rd_o with Out_valid_o=1 after edge N, i.e. one cycle.
- Throughput: one instruction per cycle while Out_ready_i=1.
- Outputs stable while Out_valid_o && !Out_ready_i except for held-refresh updates, which take effect after the writeback edge.
- Writeback visible to a read one cycle later via register file, same cycle via bypass.

## Test plan
- Reset then Wb(rd=3, 0x0000_00AA), next cycle issue Rs1=3, Rs2=0, UseImm=0, Op=ADD -> one cycle later A_o=0xAA, B_o=0, Out_valid_o=1.
- Same-cycle bypass: Wb(rd=5, 0x1234_5678) and issue Rs1=5, Rs2=5 -> A_o=B_o=0x1234_5678; Wb to rd=0 with 0xFFFF_FFFF then read x0 -> 0.
- Immediate: UseImm=1, Imm=0xFFFF_FFF0, Rs2=5 -> B_o=0xFFFF_FFF0 regardless of reg[5]; later stalled Wb to rd=5 leaves B_o unchanged.
- Stall refresh: hold Out_ready_i=0 with held Rs1=7, Rs2=7; Wb(rd=7, 0xDEAD_BEEF) -> next cycle A_o=B_o=0xDEAD_BEEF, Out_valid_o stays 1, In_ready_o=0.
- Back-to-back stream: 4 instructions with Out_ready_i=1 every cycle -> 4 consecutive Out_valid_o cycles, order preserved; Out_ready_i toggled 1/0 -> no loss, no duplication.
- Async reset asserted mid-stall -> Out_valid_o=0 and A_o=0 without a clock edge; previously written registers read 0 afterwards.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register file, operand resolve with writeback bypass,
// and a one-entry valid/ready issue register feeding the ALU.
module alu_operand_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 4,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  In_valid_i,
    output logic                  In_ready_o,
    input  logic [REG_ADDR_W-1:0] Rs1_i,
    input  logic [REG_ADDR_W-1:0] Rs2_i,
    input  logic [DATA_WIDTH-1:0] Imm_i,
    input  logic                  UseImm_i,
    input  logic [OP_WIDTH-1:0]   Op_i,
    input  logic [REG_ADDR_W-1:0] Rd_i,
    output logic                  Out_valid_o,
    input  logic                  Out_ready_i,
    output logic [DATA_WIDTH-1:0] A_o,
    output logic [DATA_WIDTH-1:0] B_o,
    output logic [OP_WIDTH-1:0]   Op_o,
    output logic [REG_ADDR_W-1:0] Rd_o,
    input  logic                  Wb_en_i,
    input  logic [REG_ADDR_W-1:0] Wb_rd_i,
    input  logic [DATA_WIDTH-1:0] Wb_data_i
);

    localparam int unsigned NREGS = 1 << REG_ADDR_W;

    logic [DATA_WIDTH-1:0] rf_q [NREGS];

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic                  use_imm_q, use_imm_d;

    logic                  wb_write_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] src_a_c;
    logic [DATA_WIDTH-1:0] src_b_c;

    // A writeback to x0 is architecturally a no-op, so it neither writes nor bypasses.
    assign wb_write_c  = Wb_en_i && (Wb_rd_i != '0);
    assign In_ready_o  = !valid_q || Out_ready_i;
    assign accept_c    = In_valid_i && In_ready_o;

    assign Out_valid_o = valid_q;
    assign A_o         = a_q;
    assign B_o         = b_q;
    assign Op_o        = op_q;
    assign Rd_o        = rd_q;

    // Resolve source operands: x0 reads zero, same-cycle writeback wins over the file.
    always_comb begin
        src_a_c = '0;
        src_b_c = '0;
        if (Rs1_i != '0) begin
            src_a_c = (wb_write_c && (Wb_rd_i == Rs1_i)) ? Wb_data_i : rf_q[Rs1_i];
        end
        if (Rs2_i != '0) begin
            src_b_c = (wb_write_c && (Wb_rd_i == Rs2_i)) ? Wb_data_i : rf_q[Rs2_i];
        end
        if (UseImm_i) begin
            src_b_c = Imm_i;
        end
    end

    // Register file write port; x0 is never written so it stays zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_q <= '{default: '0};
        end else if (wb_write_c) begin
            rf_q[Wb_rd_i] <= Wb_data_i;
        end
    end

    // Issue entry next state: load on accept, clear on drain, refresh while stalled.
    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        if (accept_c) begin
            valid_d   = 1'b1;
            a_d       = src_a_c;
            b_d       = src_b_c;
            op_d      = Op_i;
            rd_d      = Rd_i;
            rs1_d     = Rs1_i;
            rs2_d     = Rs2_i;
            use_imm_d = UseImm_i;
        end else if (valid_q && Out_ready_i) begin
            valid_d = 1'b0;
        end else if (valid_q && wb_write_c) begin
            if (Wb_rd_i == rs1_q) begin
                a_d = Wb_data_i;
            end
            if ((Wb_rd_i == rs2_q) && !use_imm_q) begin
                b_d = Wb_data_i;
            end
        end
    end

    // Issue entry state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios plus a randomized
// stream checked against an instruction-level reference model.
module tb_alu_operand_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 4;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic [DW-1:0] imm = '0;
    logic          use_imm = 1'b0;
    logic [OW-1:0] op = '0;
    logic [AW-1:0] rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic [OW-1:0] op_out;
    logic [AW-1:0] rd_out;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural registers plus the one held instruction.
    logic [DW-1:0] mregs [32];
    logic          m_valid;
    logic [DW-1:0] m_a, m_b;
    logic [OW-1:0] m_op;
    logic [AW-1:0] m_rd, m_rs1, m_rs2;
    logic          m_imm;

    alu_operand_stage #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .REG_ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .In_valid_i(in_valid), .In_ready_o(in_ready),
        .Rs1_i(rs1), .Rs2_i(rs2), .Imm_i(imm), .UseImm_i(use_imm),
        .Op_i(op), .Rd_i(rd),
        .Out_valid_o(out_valid), .Out_ready_i(out_ready),
        .A_o(a_out), .B_o(b_out), .Op_o(op_out), .Rd_o(rd_out),
        .Wb_en_i(wb_en), .Wb_rd_i(wb_rd), .Wb_data_i(wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (wb_en && wb_rd == r) return wb_data;
        return mregs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
        m_rs1 = '0; m_rs2 = '0; m_imm = 1'b0;
    endtask

    // Advance the model by one instruction-level step, then clock the DUT.
    task automatic cycle();
        logic acc;
        acc = in_valid && (!m_valid || out_ready);
        if (rst) begin
            model_reset();
        end else begin
            if (acc) begin
                m_a = mread(rs1);
                m_b = use_imm ? imm : mread(rs2);
                m_op = op; m_rd = rd; m_rs1 = rs1; m_rs2 = rs2; m_imm = use_imm;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end else if (m_valid && wb_en && wb_rd != 0) begin
                if (wb_rd == m_rs1) m_a = wb_data;
                if (wb_rd == m_rs2 && !m_imm) m_b = wb_data;
            end
            if (wb_en && wb_rd != 0) mregs[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic ui, input logic [DW-1:0] im,
                         input logic [OW-1:0] o, input logic [AW-1:0] d);
        in_valid = 1'b1; rs1 = s1; rs2 = s2; use_imm = ui; imm = im; op = o; rd = d;
    endtask

    task automatic idle();
        in_valid = 1'b0; wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); out_ready = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        cycle(); cycle();
        n_checks++;
        if ({out_valid, a_out, b_out, op_out, rd_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b a=%h b=%h op=%h rd=%h exp all 0", out_valid, a_out, b_out, op_out, rd_out);
        end
        rst = 1'b0;
        cycle();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got rdy=%b v=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_wb_then_read();
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_00AA;
        cycle();
        wb_en = 1'b0;
        issue(5'd3, 5'd0, 1'b0, '0, 4'd1, 5'd9);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || a_out !== 32'hAA || b_out !== 32'h0 || op_out !== 4'd1 || rd_out !== 5'd9) begin
            n_fail++;
            $display("FAIL wb_read got v=%b a=%h b=%h op=%h rd=%h exp 1 aa 0 1 9", out_valid, a_out, b_out, op_out, rd_out);
        end
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wb_read_drain got v=%b exp 0", out_valid); end
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
        issue(5'd5, 5'd5, 1'b0, '0, 4'd2, 5'd1);
        cycle();
        n_checks++;
        if (a_out !== 32'h1234_5678 || b_out !== 32'h1234_5678 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bypass got a=%h b=%h v=%b exp 12345678 x2 1", a_out, b_out, out_valid);
        end
        in_valid = 1'b0;
        wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        cycle();
        wb_en = 1'b0;
        issue(5'd0, 5'd0, 1'b0, '0, 4'd3, 5'd2);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (a_out !== 32'h0 || b_out !== 32'h0) begin
            n_fail++; $display("FAIL x0_read got a=%h b=%h exp 0 0", a_out, b_out);
        end
        cycle();
    endtask

    task automatic test_imm();
        out_ready = 1'b0;
        issue(5'd5, 5'd5, 1'b1, 32'hFFFF_FFF0, 4'd4, 5'd6);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (b_out !== 32'hFFFF_FFF0 || a_out !== 32'h1234_5678) begin
            n_fail++; $display("FAIL imm got a=%h b=%h exp 12345678 fffffff0", a_out, b_out);
        end
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_0055;
        cycle();
        wb_en = 1'b0;
        n_checks++;
        if (b_out !== 32'hFFFF_FFF0 || a_out !== 32'h55 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL imm_stall_wb got a=%h b=%h v=%b exp 55 fffffff0 1", a_out, b_out, out_valid);
        end
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_stall_refresh();
        out_ready = 1'b0;
        issue(5'd7, 5'd7, 1'b0, '0, 4'd5, 5'd7);
        cycle();
        n_checks++;
        if (out_valid !== 1'b1 || a_out !== 32'h0 || b_out !== 32'h0) begin
            n_fail++; $display("FAIL stall_load got v=%b a=%h b=%h exp 1 0 0", out_valid, a_out, b_out);
        end
        issue(5'd1, 5'd2, 1'b0, '0, 4'd6, 5'd8);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", in_ready); end
        cycle();
        wb_en = 1'b0;
        n_checks++;
        if (a_out !== 32'hDEAD_BEEF || b_out !== 32'hDEAD_BEEF || out_valid !== 1'b1 ||
            in_ready !== 1'b0 || rd_out !== 5'd7) begin
            n_fail++;
            $display("FAIL stall_refresh got a=%h b=%h v=%b rdy=%b rd=%0d exp deadbeef x2 1 0 7",
                     a_out, b_out, out_valid, in_ready, rd_out);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got v=%b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), 1'b0, '0,
                  OW'(i + 8), AW'(i + 16));
            cycle();
            n_checks++;
            if (out_valid !== 1'b1 || rd_out !== AW'(i + 16) || op_out !== OW'(i + 8) ||
                a_out !== m_a || b_out !== m_b) begin
                n_fail++;
                $display("FAIL b2b[%0d] got v=%b rd=%0d op=%0d a=%h b=%h exp 1 %0d %0d %h %h",
                         i, out_valid, rd_out, op_out, a_out, b_out, i + 16, i + 8, m_a, m_b);
            end
        end
        in_valid = 1'b0;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got v=%b exp 0", out_valid); end
    endtask

    // Random stream with toggling Out_ready_i; Rd carries a sequence tag.
    task automatic test_random_stream();
        int q[$];
        int seq;
        int accepted;
        int consumed;
        logic [AW-1:0] held_rs;
        seq = 0; accepted = 0; consumed = 0;
        for (int i = 0; i < 300; i++) begin
            out_ready = (i < 100) ? logic'(i % 2) : logic'($urandom_range(0, 1));
            in_valid  = logic'($urandom_range(0, 3) != 0);
            rs1 = AW'($urandom_range(0, 31)); rs2 = AW'($urandom_range(0, 31));
            use_imm = logic'($urandom_range(0, 1)); imm = DW'($urandom);
            op = OW'(seq); rd = AW'(seq);
            held_rs = ($urandom_range(0, 1) != 0) ? m_rs1 : m_rs2;
            wb_en = logic'($urandom_range(0, 1));
            wb_rd = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 31)) : held_rs;
            wb_data = DW'($urandom);
            #1;
            if (out_valid && out_ready) begin
                consumed++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL stream_dup got rd=%0d exp nothing pending", rd_out);
                end else begin
                    if (rd_out !== AW'(q[0])) begin
                        n_fail++; $display("FAIL stream_order got rd=%0d exp %0d", rd_out, AW'(q[0]));
                    end
                    void'(q.pop_front());
                end
            end
            if (in_valid && (!m_valid || out_ready)) begin
                q.push_back(seq); seq++; accepted++;
            end
            cycle();
            n_checks++;
            if (out_valid !== m_valid ||
                (m_valid && (a_out !== m_a || b_out !== m_b || op_out !== m_op || rd_out !== m_rd))) begin
                n_fail++;
                $display("FAIL stream[%0d] got v=%b a=%h b=%h op=%h rd=%0d exp v=%b a=%h b=%h op=%h rd=%0d",
                         i, out_valid, a_out, b_out, op_out, rd_out, m_valid, m_a, m_b, m_op, m_rd);
            end
        end
        idle(); out_ready = 1'b1;
        #1;
        if (out_valid) begin consumed++; void'(q.pop_front()); end
        cycle();
        n_checks++;
        if (accepted !== consumed || q.size() != 0 || accepted < 50) begin
            n_fail++; $display("FAIL stream_count got acc=%0d cons=%0d left=%0d exp equal, none left, >=50",
                               accepted, consumed, q.size());
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0099;
        cycle();
        wb_en = 1'b0; out_ready = 1'b0;
        issue(5'd9, 5'd9, 1'b0, '0, 4'd7, 5'd3);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (a_out !== 32'h99 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset got a=%h v=%b exp 99 1", a_out, out_valid);
        end
        wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h0000_0010;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || a_out !== 32'h0 || b_out !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset got v=%b a=%h b=%h rdy=%b exp 0 0 0 1", out_valid, a_out, b_out, in_ready);
        end
        cycle();
        rst = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        issue(5'd9, 5'd10, 1'b0, '0, 4'd1, 5'd1);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (a_out !== 32'h0 || b_out !== 32'h0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_regs got a=%h b=%h v=%b exp 0 0 1", a_out, b_out, out_valid);
        end
        issue(5'd3, 5'd5, 1'b0, '0, 4'd1, 5'd1);
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (a_out !== 32'h0 || b_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs2 got a=%h b=%h exp 0 0", a_out, b_out);
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_wb_then_read();
        test_bypass();
        test_imm();
        test_stall_refresh();
        test_back_to_back();
        test_random_stream();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
